// File: rtl/trace_uart_tx.sv
// Commit-trace UART transmitter: buffers retired-instruction records and sends each as an 8N1 byte frame.
// Define TRACE_CHECKSUM_EN to append an XOR checksum byte over the payload (sync byte excluded).
module trace_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [31:0] rec_pc,
  input  logic [31:0] rec_inst,
  input  logic [4:0]  rec_wb_addr,
  input  logic        rec_wen,
  input  logic [31:0] rec_wb_data,
  input  logic        exit,
  output logic        txd,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = 104;
`ifdef TRACE_CHECKSUM_EN
  localparam int NBYTES = 15;
`else
  localparam int NBYTES = 14;
`endif
  localparam int FW = 8 * NBYTES;
  localparam logic [3:0]    LAST_BYTE = 4'(NBYTES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, exit_seen;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [FW-1:0] frame_sr, frame_load;
  logic [7:0]    cur_byte;
  logic          bit_end, last_byte, txd_next;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign rec_ready = !full && !exit_seen;
  assign push      = rec_valid && rec_ready;
  assign bit_end   = (clk_cnt == BIT_LAST);
  assign last_byte = (byte_idx == LAST_BYTE);
  // The next record is loaded either from IDLE or in the final cycle of the last stop bit, so frames abut.
  assign pop       = !empty && ((state == IDLE) || (state == STOP && bit_end && last_byte));
  assign busy      = (state != IDLE) || !empty;
  assign head      = mem[rd_ptr];
  assign cur_byte  = frame_sr[FW-1 -: 8];

`ifdef TRACE_CHECKSUM_EN
  function automatic logic [7:0] payload_xor(input logic [PW-1:0] p);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < 13; i++) c = c ^ p[8*i +: 8];
    return c;
  endfunction
  assign frame_load = {8'hA5, head, payload_xor(head)};
`else
  assign frame_load = {8'hA5, head};
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rec_pc, rec_inst, rec_wen, 2'b00, rec_wb_addr, rec_wb_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      txd   <= 1'b1;
    end else begin
      state <= state_next;
      txd   <= txd_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!empty) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_end) state_next = (!last_byte || !empty) ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    txd_next = 1'b1;
    case (state)
      START:   txd_next = 1'b0;
      DATA:    txd_next = cur_byte[bit_idx];
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frame_sr <= '0;
    end else begin
      if (state == IDLE || bit_end) clk_cnt <= '0;
      else                          clk_cnt <= clk_cnt + CW'(1);
      if (state == START)                bit_idx <= '0;
      else if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (pop) begin
        frame_sr <= frame_load;
        byte_idx <= '0;
      end else if (state == STOP && bit_end) begin
        frame_sr <= {frame_sr[FW-9:0], 8'h00};
        byte_idx <= byte_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exit_seen <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (exit) exit_seen <= 1'b1;
      if (rec_valid && !rec_ready && !exit_seen) overflow <= 1'b1;
      if (exit_seen && !busy) done <= 1'b1;
    end
  end

endmodule

// File: doc/trace_uart_tx.md
Name: trace_uart_tx

Overview:
- Commit-trace transmitter on the core side of the debug path.
- Accepts one retired-instruction record per handshake: pc, inst, write-back address/enable, write-back data.
- Buffers records in a small FIFO and serializes each as a fixed byte frame over an 8N1 UART line, so a host receiver can reconstruct the per-instruction trace.
- Reports end of program once the core's exit is seen and every buffered frame has been transmitted.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (>= 2)
- DEPTH, 4, FIFO depth in records (power of 2, >= 2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset; single clock domain, all state sampled on rising clk
- rec_valid  input  1  record present this cycle
- rec_ready  output  1  record accepted when rec_valid && rec_ready
- rec_pc  input  32  retired pc
- rec_inst  input  32  retired instruction
- rec_wb_addr  input  5  destination register
- rec_wen  input  1  register write enable
- rec_wb_data  input  32  write-back data
- exit  input  1  core exit indication (level)
- txd  output  1  UART serial out, idle high
- busy  output  1  frame in progress or FIFO non-empty
- overflow  output  1  sticky: a record was dropped
- done  output  1  sticky: exit seen and all frames sent

Behaviour:
- Reset values: txd=1, rec_ready=1, busy=0, overflow=0, done=0; FIFO empty; state IDLE; exit latch cleared.
- Reset mid-frame: txd returns to 1 on the next edge, the partial frame is abandoned and the FIFO is flushed.
- Accept and FIFO:
  - rec_ready = !full && !exit_seen.
  - An accepted record is written at that edge.
  - Push and pop in the same cycle are allowed when not full.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- overflow:
  - Set when rec_valid && !rec_ready && !exit_seen.
  - Cleared only by rst.
- Frame format, 14 bytes, sent in order:
  - 0xA5 sync byte.
  - pc[31:24], pc[23:16], pc[15:8], pc[7:0].
  - inst bytes, MSB first.
  - {rec_wen, 2'b00, rec_wb_addr}.
  - wb_data bytes, MSB first.
- Byte timing:
  - Start bit 0, then data bits LSB first, then one stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bytes within a frame and consecutive frames are back-to-back, with no idle gap beyond the stop bit.
- State machine:
  - IDLE: if the FIFO is non-empty, pop into the frame shift register, clear the byte index, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd = current byte bit[idx] for CLKS_PER_BIT cycles each; after bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
    - If the byte index < last, increment it and go to START.
    - Otherwise, if the FIFO is non-empty, pop the next record and go to START.
    - Otherwise go to IDLE.
- Latency: a record accepted at edge N into an empty FIFO while IDLE is popped at edge N+1; txd is first low after edge N+2.
- Frame duration: 14*10*CLKS_PER_BIT cycles.
- exit handling:
  - exit_seen latches on any cycle exit=1.
  - A record presented in that same cycle is still accepted if the FIFO is not full.
  - Once exit_seen is set, rec_ready=0.
- busy = (state != IDLE) || !empty.
- done = exit_seen && !busy; registered and sticky until rst.

Optional Feature:
- Macro: TRACE_CHECKSUM_EN.
- Defined:
  - A 15th byte is appended: XOR of the 13 payload bytes (the sync byte is excluded).
  - Frame duration becomes 15*10*CLKS_PER_BIT cycles.
- Undefined: frame is 14 bytes and no checksum logic is present.

Test Plan:
- Single record (CLKS_PER_BIT=4): pc=0x00000004, inst=0x00500093, wb_addr=1, wen=1, wb_data=0x00000005.
  - Decode txd to bytes A5 00 00 00 04 00 50 00 93 81 00 00 00 05.
  - First start bit begins 2 cycles after accept.
  - 560 cycles total; txd=1 afterward.
- Back-to-back (DEPTH=4): push 6 records on consecutive cycles while the first frame is in progress.
  - rec_ready drops once the FIFO is full; overflow=1 after the first refused record.
  - Every accepted record is transmitted in order, with no gap between frames.
- wen=0, wb_addr=31 -> address byte 0x1F.
- exit asserted together with a final record while 2 records are buffered:
  - rec_ready=0 from the next cycle; a later rec_valid does not set overflow.
  - done rises within 1 cycle after the last stop bit of frame 3.
- rst asserted in the middle of a data byte:
  - txd=1, busy=0, done=0, overflow=0 on the next edge.
  - A new record then produces a clean frame.
- TRACE_CHECKSUM_EN with the record from the single-record case:
  - 15th byte = 0x00^0x00^0x00^0x04^0x00^0x50^0x00^0x93^0x81^0x00^0x00^0x00^0x05 = 0x43.
